// File: rtl/lockout_timer_if.sv
// Keypad lockout bus: lock request / admin clear in, lock status and alarm out.
interface lockout_timer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             lock_req;
  logic             admin_clr;
  logic             locked;
  logic             keypad_enb;
  logic             clr_attempts;
  logic [CNT_W-1:0] sec_left;
  logic [1:0]       strikes;
  logic [2:0]       led_4;

  // Controller side: drives requests, observes lockout status.
  modport master (
    output lock_req, admin_clr,
    input  locked, keypad_enb, clr_attempts, sec_left, strikes, led_4
  );

  // Lockout timer side.
  modport slave (
    input  lock_req, admin_clr,
    output locked, keypad_enb, clr_attempts, sec_left, strikes, led_4
  );
endinterface

// File: rtl/lockout_timer.sv
// Timed keypad lockout with per-second countdown, blinking red alarm and
// strike escalation (lockout length doubles per completed lockout, max x8).
module lockout_timer #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned LOCK_SEC = 30,
  parameter int unsigned CNT_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  lockout_timer_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOCKED,
    S_RELEASE
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_lreq_s;
  logic [PW-1:0]    r_presc;
  logic             r_blink;
  logic [CNT_W-1:0] r_sec_left;
  logic [1:0]       r_strikes;
  logic             r_locked;
  logic             r_clr;
  logic [2:0]       r_led;

  logic             w_tick;
  logic [CNT_W-1:0] w_load;
  logic [1:0]       w_strikes_inc;

  assign w_tick        = (r_presc == PW'(TICK_DIV - 1));
  assign w_load        = CNT_W'(LOCK_SEC << r_strikes);
  assign w_strikes_inc = (r_strikes == 2'd3) ? 2'd3 : r_strikes + 2'd1;

  // Two-flop synchroniser for the asynchronous lock request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= 1'b0;
      r_lreq_s <= 1'b0;
    end else begin
      r_sync1  <= bus.lock_req;
      r_lreq_s <= r_sync1;
    end
  end

  // Lockout FSM with countdown, blink and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_presc    <= '0;
      r_blink    <= 1'b0;
      r_sec_left <= '0;
      r_strikes  <= '0;
      r_locked   <= 1'b0;
      r_clr      <= 1'b0;
      r_led      <= 3'b000;
    end else if (bus.admin_clr) begin
      r_strikes <= '0;
      if (r_state == S_LOCKED) begin
        r_state    <= S_RELEASE;
        r_sec_left <= '0;
        r_locked   <= 1'b0;
        r_clr      <= 1'b1;
        r_led      <= 3'b010;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_lreq_s) begin
            r_state    <= S_LOCKED;
            r_sec_left <= w_load;
            r_presc    <= '0;
            r_blink    <= 1'b1;
            r_locked   <= 1'b1;
            r_led      <= 3'b100;
          end
        end
        S_LOCKED: begin
          if (w_tick) begin
            r_presc <= '0;
            r_blink <= ~r_blink;
            // LED follows the post-toggle blink value.
            r_led   <= r_blink ? 3'b000 : 3'b100;
            if (r_sec_left == CNT_W'(1)) begin
              r_state    <= S_RELEASE;
              r_sec_left <= '0;
              r_strikes  <= w_strikes_inc;
              r_locked   <= 1'b0;
              r_clr      <= 1'b1;
              r_led      <= 3'b010;
            end else begin
              r_sec_left <= r_sec_left - CNT_W'(1);
            end
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end
        S_RELEASE: begin
          if (!r_lreq_s) begin
            r_state <= S_IDLE;
            r_clr   <= 1'b0;
            r_led   <= 3'b000;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_locked <= 1'b0;
          r_clr    <= 1'b0;
          r_led    <= 3'b000;
        end
      endcase
    end
  end

  assign bus.locked       = r_locked;
  assign bus.keypad_enb   = ~r_locked;
  assign bus.clr_attempts = r_clr;
  assign bus.sec_left     = r_sec_left;
  assign bus.strikes      = r_strikes;
  assign bus.led_4        = r_led;

endmodule

// File: tb/tb_lockout_timer.sv
// Directed bench for lockout_timer with TICK_DIV=4, LOCK_SEC=3, CNT_W=8.
module tb_lockout_timer;

  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned failures;

  lockout_timer_if #(.CNT_W(8)) bus ();

  lockout_timer #(
    .TICK_DIV (4),
    .LOCK_SEC (3),
    .CNT_W    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk_eq({tag, "_locked"}, 32'(bus.locked), 32'd0);
    chk_eq({tag, "_keypad"}, 32'(bus.keypad_enb), 32'd1);
    chk_eq({tag, "_clr"}, 32'(bus.clr_attempts), 32'd0);
    chk_eq({tag, "_led"}, 32'(bus.led_4), 32'd0);
    chk_eq({tag, "_sec"}, 32'(bus.sec_left), 32'd0);
  endtask

  // Full lockout: request, countdown to expiry, then drop request back to IDLE.
  task automatic do_lock(input string tag, input int unsigned init, input int unsigned strk);
    bus.lock_req = 1'b1;
    step(2);
    chk_eq({tag, "_prelock"}, 32'(bus.locked), 32'd0);
    step(1);
    chk_eq({tag, "_locked"}, 32'(bus.locked), 32'd1);
    chk_eq({tag, "_init"}, 32'(bus.sec_left), init);
    chk_eq({tag, "_keypad"}, 32'(bus.keypad_enb), 32'd0);
    step(4 * init - 1);
    chk_eq({tag, "_last"}, 32'(bus.sec_left), 32'd1);
    step(1);
    chk_eq({tag, "_rel_clr"}, 32'(bus.clr_attempts), 32'd1);
    chk_eq({tag, "_rel_led"}, 32'(bus.led_4), 32'b010);
    chk_eq({tag, "_strikes"}, 32'(bus.strikes), strk);
    bus.lock_req = 1'b0;
    step(3);
    chk_idle({tag, "_idle"});
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    bus.lock_req  = 1'b0;
    bus.admin_clr = 1'b0;

    // Reset state
    step(3);
    chk_idle("rst");
    chk_eq("rst_strikes", 32'(bus.strikes), 32'd0);
    rst = 1'b1;
    step(2);
    chk_idle("post_rst");

    // Basic lock: 3-edge latency, 4-cycle seconds, blinking red
    bus.lock_req = 1'b1;
    step(2);
    chk_eq("lat2_locked", 32'(bus.locked), 32'd0);
    step(1);
    chk_eq("lat3_locked", 32'(bus.locked), 32'd1);
    chk_eq("lat3_keypad", 32'(bus.keypad_enb), 32'd0);
    chk_eq("s3_sec", 32'(bus.sec_left), 32'd3);
    chk_eq("s3_led", 32'(bus.led_4), 32'b100);
    step(3);
    chk_eq("s3_hold", 32'(bus.sec_left), 32'd3);
    step(1);
    chk_eq("s2_sec", 32'(bus.sec_left), 32'd2);
    chk_eq("s2_led", 32'(bus.led_4), 32'b000);
    step(4);
    chk_eq("s1_sec", 32'(bus.sec_left), 32'd1);
    chk_eq("s1_led", 32'(bus.led_4), 32'b100);
    step(4);
    chk_eq("exp_sec", 32'(bus.sec_left), 32'd0);
    chk_eq("exp_locked", 32'(bus.locked), 32'd0);
    chk_eq("exp_clr", 32'(bus.clr_attempts), 32'd1);
    chk_eq("exp_led", 32'(bus.led_4), 32'b010);
    chk_eq("exp_strikes", 32'(bus.strikes), 32'd1);

    // Release handshake: RELEASE holds while the request stays high
    step(5);
    chk_eq("hold_clr", 32'(bus.clr_attempts), 32'd1);
    bus.lock_req = 1'b0;
    step(2);
    chk_eq("drop2_clr", 32'(bus.clr_attempts), 32'd1);
    step(1);
    chk_idle("drop3");

    // Escalation 6, 12, 24, 24 with strikes saturating at 3
    do_lock("esc1", 6, 2);
    do_lock("esc2", 12, 3);
    do_lock("esc3", 24, 3);
    do_lock("esc4", 24, 3);

    // admin_clr in IDLE clears strikes only
    bus.admin_clr = 1'b1;
    step(1);
    bus.admin_clr = 1'b0;
    chk_eq("adm_idle_strikes", 32'(bus.strikes), 32'd0);
    chk_idle("adm_idle");
    do_lock("base", 3, 1);

    // admin_clr mid-lock at sec_left=5 with strikes=1
    bus.lock_req = 1'b1;
    step(3);
    chk_eq("adm_init", 32'(bus.sec_left), 32'd6);
    step(4);
    chk_eq("adm_sec5", 32'(bus.sec_left), 32'd5);
    bus.admin_clr = 1'b1;
    bus.lock_req  = 1'b0;
    step(1);
    bus.admin_clr = 1'b0;
    chk_eq("adm_clr", 32'(bus.clr_attempts), 32'd1);
    chk_eq("adm_sec", 32'(bus.sec_left), 32'd0);
    chk_eq("adm_strikes", 32'(bus.strikes), 32'd0);
    chk_eq("adm_locked", 32'(bus.locked), 32'd0);
    step(3);
    chk_idle("adm_after");
    do_lock("adm_next", 3, 1);

    // Asynchronous reset mid-lock at sec_left=2
    bus.lock_req = 1'b1;
    step(3);
    chk_eq("ar_init", 32'(bus.sec_left), 32'd6);
    step(16);
    chk_eq("ar_sec2", 32'(bus.sec_left), 32'd2);
    #3;
    rst = 1'b0;
    #1;
    chk_idle("ar_now");
    chk_eq("ar_strikes", 32'(bus.strikes), 32'd0);
    step(2);
    rst = 1'b1;
    step(2);
    chk_eq("ar_lat2", 32'(bus.locked), 32'd0);
    step(1);
    chk_eq("ar_lat3", 32'(bus.locked), 32'd1);
    chk_eq("ar_sec", 32'(bus.sec_left), 32'd3);

    // Request glitch while LOCKED is ignored
    bus.lock_req = 1'b0;
    step(1);
    bus.lock_req = 1'b1;
    step(1);
    bus.lock_req = 1'b0;
    step(1);
    chk_eq("gl_sec3", 32'(bus.sec_left), 32'd3);
    step(1);
    chk_eq("gl_sec2", 32'(bus.sec_left), 32'd2);
    chk_eq("gl_strikes", 32'(bus.strikes), 32'd0);
    step(4);
    chk_eq("gl_sec1", 32'(bus.sec_left), 32'd1);
    step(4);
    chk_eq("gl_rel_clr", 32'(bus.clr_attempts), 32'd1);
    chk_eq("gl_rel_strikes", 32'(bus.strikes), 32'd1);
    step(3);
    chk_idle("gl_idle");
    step(5);
    chk_eq("gl_no_relock", 32'(bus.locked), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lockout_timer.md
Name: lockout_timer

Overview:
- Receives the "three failed attempts" enable from the attempt counter and enforces a timed keypad lockout.
- While locked it blocks keypad entry, counts the remaining seconds down and blinks a red alarm LED.
- On expiry it clears the attempt counter and re-arms itself.
- Lockout length doubles on each consecutive lockout (strike escalation) until an admin clear.

Parameters:
- TICK_DIV, 100000000: clk cycles per 1-second tick; must be >=2.
- LOCK_SEC, 30: base lockout length in seconds; must be >=1.
- CNT_W, 8: width of sec_left; requires (LOCK_SEC<<3) < 2**CNT_W.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- lock_req  in  1  level from attempt counter, high when 3 attempts have failed; asynchronous to clk.
- admin_clr  in  1  synchronous one-cycle pulse: clears strikes and aborts any lockout.
- locked  out  1  high while lockout is active.
- keypad_enb  out  1  equal to ~locked.
- clr_attempts  out  1  high in the RELEASE state; drives the attempt counter reset.
- sec_left  out  CNT_W  seconds remaining; 0 when not locked.
- strikes  out  2  number of completed lockouts, saturating at 3.
- led_4  out  3  RGB alarm LED code.

Behaviour:
- Reset (rst=0, asynchronous), takes effect mid-operation as well:
  - state=IDLE, locked=0, keypad_enb=1, clr_attempts=0, sec_left=0, strikes=0, led_4=000.
  - Prescaler=0, sync flops=0, blink=0.
- Input synchronisation: lock_req passes through 2 flops; lreq_s is the second flop.
- States:
  - IDLE: led_4=000. When lreq_s=1 -> LOCKED.
    - On entry to LOCKED: sec_left <= LOCK_SEC<<strikes, prescaler <= 0, blink <= 1.
    - Latency: lock_req rising to locked=1 is 3 clk edges.
  - LOCKED: locked=1, led_4 = blink ? 100 : 000.
    - Prescaler counts 0..TICK_DIV-1. tick is asserted when prescaler==TICK_DIV-1; prescaler then wraps to 0.
    - On tick: blink toggles; sec_left decrements.
    - If sec_left==1 at the tick: sec_left <= 0, strikes <= min(strikes+1, 3), go to RELEASE.
    - lreq_s is ignored while LOCKED.
  - RELEASE: clr_attempts=1, locked=0, led_4=010 (green), sec_left=0.
    - Stays in RELEASE while lreq_s=1.
    - Goes to IDLE on the first cycle with lreq_s=0.
    - Minimum RELEASE length is 1 cycle.
- admin_clr=1 (highest priority after reset, any state):
  - strikes <= 0.
  - If LOCKED: go to RELEASE with sec_left <= 0. strikes is NOT incremented.
  - In IDLE or RELEASE: state unchanged.
- Lockout durations: LOCK_SEC<<0, <<1, <<2, <<3 for strikes 0..3; strikes=3 stays at <<3.
- The first tick after entering LOCKED occurs exactly TICK_DIV cycles after entry, so every second is a full second.
- No combinational path from lock_req to any output. All outputs are registered or decoded from state registers.

Test Plan (TICK_DIV=4, LOCK_SEC=3, CNT_W=8):
- Reset and basic lock: hold rst=0, then release; raise lock_req.
  - Response: locked=1 on the 3rd edge, sec_left=3.
  - Then 2 -> 1 -> 0 at 4-cycle intervals; led_4 alternates 100/000 each second.
  - Then clr_attempts=1, led_4=010, strikes=1.
- Release handshake: keep lock_req high for 5 cycles after expiry.
  - Response: clr_attempts stays 1 until 2 cycles after lock_req falls, then IDLE with keypad_enb=1.
- Escalation: perform 4 consecutive lockouts.
  - Response: initial sec_left = 6, 12, 24, then 24 again; strikes saturates at 3.
- admin_clr mid-lock: pulse admin_clr at sec_left=5 with strikes=1.
  - Response: next cycle RELEASE, sec_left=0, strikes=0.
  - Next lockout loads sec_left=3.
- Asynchronous reset mid-lock: drive rst=0 between clk edges while sec_left=2.
  - Response: all outputs return to reset values immediately.
  - lock_req still high after rst returns to 1: a new lockout with sec_left=3 after 3 edges.
- Glitch and ignore: pulse lock_req for 1 cycle while LOCKED.
  - Response: no change to sec_left or strikes.
